// File: rtl/ifetch_bp_pkg.sv
// Shared constants, types and predecode helper for the fetch unit.
package ifetch_bp_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Counters start weakly not-taken.
  localparam logic [1:0] BHT_INIT = 2'b01;

  // Queue entry layout: {ins[31:0], pc[31:0], pred}.
  localparam int unsigned IQ_ENTRY_W = 65;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        pred;
    logic [31:0] next_pc;
  } predict_t;

  // Static next-PC prediction for one fetched word; bht_msb is the
  // taken/not-taken opinion of the counter indexed by this pc.
  function automatic predict_t predecode(input logic [31:0] ins,
                                         input logic [31:0] pc,
                                         input logic        bht_msb);
    predict_t    res;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    res.pred    = 1'b0;
    res.next_pc = pc + 32'd4;
    case (ins[6:0])
      OPC_JAL: begin
        res.pred    = 1'b1;
        res.next_pc = pc + j_imm;
      end
      OPC_BRANCH: begin
        res.pred = bht_msb;
        if (bht_msb) res.next_pc = pc + b_imm;
      end
      // Indirect target is unknown at fetch: fall through.
      OPC_JALR: begin
        res.pred    = 1'b0;
        res.next_pc = pc + 32'd4;
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ifetch_bp_iq.sv
// Circular instruction queue: head/tail pointers with wrap and an occupancy count.
module ifetch_iq
  import ifetch_bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = IQ_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and count bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= next_ptr(r_tail);
      if (i_pop)  r_head <= next_ptr(r_head);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_tail] <= i_data;
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  // Head reads as zero when empty so dispatch outputs are clean after reset.
  assign o_data  = o_empty ? '0 : r_mem[r_head];

endmodule

// File: rtl/ifetch_bp.sv
// Instruction fetch with predecode-based next-PC prediction and a 2-bit BHT.
module ifetch_bp
  import ifetch_bp_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_ins,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc,
  input  logic        br_upd,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_taken,
  input  logic        dis_ready,
  output logic        dis_valid,
  output logic [31:0] dis_ins,
  output logic [31:0] dis_pc,
  output logic        dis_pred_taken
);

  localparam int unsigned BHT_N = 1 << BHT_BITS;

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_ic_req;

  logic [BHT_N-1:0]    w_bht_msb;
  logic [BHT_BITS-1:0] w_lk_idx;
  logic [BHT_BITS-1:0] w_up_idx;
  predict_t            w_pred;
  logic                w_push;
  logic                w_pop;
  logic                w_clear;
  logic                w_empty;
  logic                w_full;
  logic [IQ_ENTRY_W-1:0] w_head;
  logic                w_unused_upd_bits;

  assign w_lk_idx = r_pc[BHT_BITS+1:2];
  assign w_up_idx = br_upd_pc[BHT_BITS+1:2];
  assign w_unused_upd_bits = ^{br_upd_pc[31:BHT_BITS+2], br_upd_pc[1:0]};

  // Lookup sees the counter value from before any same-cycle update.
  assign w_pred = predecode(ic_ins, r_pc, w_bht_msb[w_lk_idx]);

  // A flush suppresses both enqueue and dequeue in its cycle.
  assign w_clear = rdy && rob_flush;
  assign w_push  = rdy && !rob_flush && (r_state == ST_WAIT) && ic_valid;
  assign w_pop   = rdy && !rob_flush && !w_empty && dis_ready;

  genvar gi;
  generate
    for (gi = 0; gi < BHT_N; gi++) begin : g_bht
      logic [1:0] r_ctr;
      // Saturating 2-bit counter, trained by resolved branches.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ctr <= BHT_INIT;
        end else if (rdy && br_upd && (w_up_idx == BHT_BITS'(gi))) begin
          if (br_upd_taken && (r_ctr != 2'b11))      r_ctr <= r_ctr + 2'b01;
          else if (!br_upd_taken && (r_ctr != 2'b00)) r_ctr <= r_ctr - 2'b01;
        end
      end
      assign w_bht_msb[gi] = r_ctr[1];
    end
  endgenerate

  // Fetch sequencer: issue, wait for the word, or swallow a flushed response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_ic_req <= 1'b0;
    end else if (rdy) begin
      if (rob_flush) begin
        r_pc     <= rob_flush_pc;
        r_ic_req <= 1'b0;
        case (r_state)
          ST_WAIT, ST_DROP: r_state <= ic_valid ? ST_IDLE : ST_DROP;
          default:          r_state <= ST_IDLE;
        endcase
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_full) begin
              r_state  <= ST_WAIT;
              r_ic_req <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (ic_valid) begin
              r_pc     <= w_pred.next_pc;
              r_state  <= ST_IDLE;
              r_ic_req <= 1'b0;
            end
          end
          ST_DROP: begin
            if (ic_valid) r_state <= ST_IDLE;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_ic_req <= 1'b0;
          end
        endcase
      end
    end
  end

  ifetch_iq #(
    .DEPTH(IQ_DEPTH),
    .WIDTH(IQ_ENTRY_W)
  ) u_iq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  ({ic_ins, r_pc, w_pred.pred}),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign ic_req    = r_ic_req;
  assign ic_addr   = r_pc;
  assign dis_valid = !w_empty;
  assign {dis_ins, dis_pc, dis_pred_taken} = w_head;

endmodule
